// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP64 field layout, rounding modes, integer
// saturation limits and the FP->int converter state encoding.
package fpu_pkg;

   localparam int EXP_W  = 11;
   localparam int FRAC_W = 52;
   localparam int BIAS   = 1023;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam logic [63:0] INT64_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] UINT64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      F2I_IDLE  = 2'd0,
      F2I_SHIFT = 2'd1,
      F2I_ROUND = 2'd2,
      F2I_DONE  = 2'd3
   } f2i_state_t;

   // Saturated integer for an out-of-range source; NaN always maps to the
   // largest positive value regardless of its sign bit.
   function automatic logic [63:0] f2i_sat(input logic sign, input logic uns, input logic nan);
      logic [63:0] v;
      if (nan) begin
         v = uns ? UINT64_MAX : INT64_MAX;
      end else if (sign) begin
         v = uns ? 64'd0 : INT64_MIN;
      end else begin
         v = uns ? UINT64_MAX : INT64_MAX;
      end
      return v;
   endfunction

endpackage

// File: rtl/fpu_f2i_if.sv
// Operand/result handshake bundle of the FP64 -> int64 converter.
interface fpu_f2i_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] operand;
   logic        is_unsigned;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        flag_nv;
   logic        flag_nx;

   modport master (
      output in_valid, operand, is_unsigned, rm, out_ready,
      input  in_ready, out_valid, result, flag_nv, flag_nx
   );

   modport slave (
      input  in_valid, operand, is_unsigned, rm, out_ready,
      output in_ready, out_valid, result, flag_nv, flag_nx
   );
endinterface

// File: rtl/fpu_round_inc.sv
// Rounding-increment decision shared by the FPU converters.
module fpu_round_inc
   import fpu_pkg::*;
(
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   input  logic [2:0] rm,
   output logic       inc
);

   // Select the increment rule; reserved encodings round to nearest-even.
   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RNE:  inc = guard & (sticky | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | lsb);
      endcase
   end

endmodule

// File: rtl/fpu_f2i.sv
// Iterative FP64 -> 64-bit integer converter (fcvt.l.d / fcvt.lu.d).
// The exponent fixes the de-normalisation distance; right shifts are
// walked off SHIFT_STEP bits per cycle while guard/sticky are collected,
// then a single ROUND cycle applies the increment and saturation.
module fpu_f2i
   import fpu_pkg::*;
#(
   parameter int SHIFT_STEP = 8
)(
   input  logic      clk,
   input  logic      rst,
   fpu_f2i_if.slave  bus
);

   localparam int REM_W = 7;

   f2i_state_t        state_r;
   logic              sign_r;
   logic              uns_r;
   logic [2:0]        rm_r;
   logic              left_r;
   logic [REM_W-1:0]  rem_r;
   logic [63:0]       mag_r;
   logic              guard_r;
   logic              sticky_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [63:0]       result_r;
   logic              nv_r;
   logic              nx_r;

   logic [EXP_W-1:0]  exp_s;
   logic [FRAC_W-1:0] frac_s;
   logic [FRAC_W:0]   m_s;
   logic signed [12:0] e_s;
   logic              is_nan_s;
   logic              special_s;

   logic [REM_W-1:0]  step_s;
   logic [5:0]        gidx_s;
   logic [63:0]       out_bits_s;
   logic [63:0]       shifted_s;
   logic              guard_nx_s;
   logic              sticky_nx_s;

   logic              inc_s;
   logic [64:0]       mag_inc_s;
   logic              ovf_s;
   logic [63:0]       rnd_res_s;

   // Decode the presented operand into exponent class and significand.
   always_comb begin
      exp_s     = bus.operand[FRAC_W +: EXP_W];
      frac_s    = bus.operand[FRAC_W-1:0];
      m_s       = {(exp_s != {EXP_W{1'b0}}), frac_s};
      e_s       = 13'({2'b00, exp_s}) - 13'(BIAS);
      is_nan_s  = (exp_s == {EXP_W{1'b1}}) && (frac_s != {FRAC_W{1'b0}});
      special_s = (exp_s == {EXP_W{1'b1}}) || (e_s >= 13'sd64);
   end

   // One right-shift step: bits leaving the magnitude feed guard and sticky.
   always_comb begin
      if (rem_r > REM_W'(SHIFT_STEP)) begin
         step_s = REM_W'(SHIFT_STEP);
      end else begin
         step_s = rem_r;
      end
      gidx_s      = 6'(step_s - 7'd1);
      out_bits_s  = mag_r & ((64'd1 << step_s) - 64'd1);
      shifted_s   = mag_r >> step_s;
      guard_nx_s  = out_bits_s[gidx_s];
      sticky_nx_s = sticky_r | guard_r |
                    ((out_bits_s & ((64'd1 << gidx_s) - 64'd1)) != 64'd0);
   end

   fpu_round_inc u_round_inc (
      .sign   (sign_r),
      .lsb    (mag_r[0]),
      .guard  (guard_r),
      .sticky (sticky_r),
      .rm     (rm_r),
      .inc    (inc_s)
   );

   // Apply the increment on a 65-bit magnitude and check the target range.
   always_comb begin
      mag_inc_s = {1'b0, mag_r} + {64'd0, inc_s};
      if (uns_r) begin
         if (sign_r) begin
            ovf_s = (mag_inc_s != 65'd0);
         end else begin
            ovf_s = mag_inc_s[64];
         end
      end else begin
         if (sign_r) begin
            ovf_s = (mag_inc_s > {1'b0, INT64_MIN});
         end else begin
            ovf_s = (mag_inc_s > {1'b0, INT64_MAX});
         end
      end
      if (ovf_s) begin
         rnd_res_s = f2i_sat(sign_r, uns_r, 1'b0);
      end else if (sign_r) begin
         rnd_res_s = 64'd0 - mag_inc_s[63:0];
      end else begin
         rnd_res_s = mag_inc_s[63:0];
      end
   end

   // Control FSM with all datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= F2I_IDLE;
         sign_r      <= 1'b0;
         uns_r       <= 1'b0;
         rm_r        <= 3'b000;
         left_r      <= 1'b0;
         rem_r       <= {REM_W{1'b0}};
         mag_r       <= 64'd0;
         guard_r     <= 1'b0;
         sticky_r    <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= 64'd0;
         nv_r        <= 1'b0;
         nx_r        <= 1'b0;
      end else begin
         case (state_r)
            F2I_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  sign_r     <= bus.operand[63];
                  uns_r      <= bus.is_unsigned;
                  rm_r       <= bus.rm;
                  guard_r    <= 1'b0;
                  sticky_r   <= 1'b0;
                  left_r     <= 1'b0;
                  rem_r      <= {REM_W{1'b0}};
                  mag_r      <= 64'(m_s);
                  if (special_s) begin
                     result_r    <= f2i_sat(bus.operand[63], bus.is_unsigned, is_nan_s);
                     nv_r        <= 1'b1;
                     nx_r        <= 1'b0;
                     out_valid_r <= 1'b1;
                     state_r     <= F2I_DONE;
                  end else if (e_s == 13'sd52) begin
                     state_r <= F2I_ROUND;
                  end else if (e_s > 13'sd52) begin
                     left_r  <= 1'b1;
                     rem_r   <= REM_W'(e_s - 13'sd52);
                     state_r <= F2I_SHIFT;
                  end else if (e_s >= -13'sd2) begin
                     rem_r   <= REM_W'(13'sd52 - e_s);
                     state_r <= F2I_SHIFT;
                  end else begin
                     // Magnitude below a quarter: only stickiness survives.
                     mag_r    <= 64'd0;
                     sticky_r <= (m_s != {(FRAC_W+1){1'b0}});
                     state_r  <= F2I_ROUND;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            F2I_SHIFT: begin
               if (left_r) begin
                  mag_r   <= mag_r << rem_r;
                  rem_r   <= {REM_W{1'b0}};
                  left_r  <= 1'b0;
                  state_r <= F2I_ROUND;
               end else begin
                  mag_r    <= shifted_s;
                  guard_r  <= guard_nx_s;
                  sticky_r <= sticky_nx_s;
                  rem_r    <= rem_r - step_s;
                  if (rem_r == step_s) begin
                     state_r <= F2I_ROUND;
                  end else begin
                     state_r <= F2I_SHIFT;
                  end
               end
            end
            F2I_ROUND: begin
               result_r    <= rnd_res_s;
               nv_r        <= ovf_s;
               nx_r        <= ~ovf_s & (guard_r | sticky_r);
               out_valid_r <= 1'b1;
               state_r     <= F2I_DONE;
            end
            F2I_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= F2I_IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               state_r     <= F2I_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.flag_nv   = nv_r;
   assign bus.flag_nx   = nx_r;

endmodule

// File: tb/tb_fpu_f2i.sv
// Self-checking bench for fpu_f2i: directed cases plus randomized operands
// checked against an exact-value reference (integer part vs. remainder).
module tb_fpu_f2i;

   localparam int STEP = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   fpu_f2i_if bus ();

   fpu_f2i #(.SHIFT_STEP(STEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck design cannot hang the run.
   initial begin
      #600000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   // Exact reference: split |x| into integer part and remainder against one half.
   task automatic model(input logic [63:0] op, input logic uns, input logic [2:0] rm_in,
                        output logic [63:0] res, output logic nv, output logic nx, output int lat);
      logic         s;
      int           ex;
      int           e;
      int           d;
      logic [51:0]  fr;
      logic [127:0] m, ip, rem, half, mag;
      logic         up, bad;
      logic [2:0]   mode;
      s    = op[63];
      ex   = int'(op[62:52]);
      fr   = op[51:0];
      m    = {75'd0, (ex != 0), fr};
      e    = ex - 1023;
      mode = (rm_in > 3'd4) ? 3'd0 : rm_in;
      nv   = 1'b0;
      nx   = 1'b0;
      res  = 64'd0;
      if (ex == 2047 || e >= 64) begin
         lat = 1;
         nv  = 1'b1;
         if (ex == 2047 && fr != 52'd0) res = uns ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
         else if (s)                    res = uns ? 64'd0 : 64'h8000_0000_0000_0000;
         else                           res = uns ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
      end else begin
         if (e >= 52) begin
            ip   = m << (e - 52);
            rem  = 128'd0;
            half = 128'd1;
            lat  = (e == 52) ? 2 : 3;
         end else if (ex != 0 && e >= -2) begin
            d    = 52 - e;
            ip   = m >> d;
            rem  = m & ((128'd1 << d) - 128'd1);
            half = 128'd1 << (d - 1);
            lat  = 2 + (d + STEP - 1) / STEP;
         end else begin
            ip   = 128'd0;
            rem  = (m != 128'd0) ? 128'd1 : 128'd0;
            half = 128'd2;
            lat  = 2;
         end
         case (mode)
            3'd0:    up = (rem > half) || (rem == half && ip[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = s && (rem != 128'd0);
            3'd3:    up = !s && (rem != 128'd0);
            default: up = (rem != 128'd0) && (rem >= half);
         endcase
         mag = ip + {127'd0, up};
         if (uns) bad = s ? (mag != 128'd0) : (mag > 128'hFFFF_FFFF_FFFF_FFFF);
         else     bad = s ? (mag > 128'h8000_0000_0000_0000) : (mag > 128'h7FFF_FFFF_FFFF_FFFF);
         if (bad) begin
            nv = 1'b1;
            if (uns) res = s ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
            else     res = s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
         end else begin
            nx  = (rem != 128'd0);
            res = s ? (64'd0 - mag[63:0]) : mag[63:0];
         end
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   // Issue one operation, measure latency, check outputs, optionally stall.
   task automatic run_op(input string tag, input logic [63:0] op, input logic uns, input logic [2:0] rmv,
                         input logic [63:0] er, input logic env, input logic enx, input int elat, input int hold);
      int lat;
      wait_ready(tag);
      bus.operand     = op;
      bus.is_unsigned = uns;
      bus.rm          = rmv;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1;
      // Keep presenting junk while busy: it must be ignored.
      bus.operand     = {$urandom, $urandom};
      bus.is_unsigned = ~uns;
      bus.rm          = 3'(~rmv);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      check_eq({tag, " latency"}, 64'(lat), 64'(elat));
      check_eq({tag, " result"}, bus.result, er);
      check_eq({tag, " nv"}, 64'(bus.flag_nv), 64'(env));
      check_eq({tag, " nx"}, 64'(bus.flag_nx), 64'(enx));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, " hold result"}, bus.result, er);
         check_eq({tag, " hold flags"}, {62'd0, bus.flag_nv, bus.flag_nx}, {62'd0, env, enx});
         check_eq({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
         check_eq({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
      check_eq({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] op, er;
      logic        uns, env, enx;
      logic [2:0]  rmv;
      int          elat;
      int          cat;

      n_checks        = 0;
      n_errors        = 0;
      bus.in_valid    = 1'b0;
      bus.operand     = 64'd0;
      bus.is_unsigned = 1'b0;
      bus.rm          = 3'd0;
      bus.out_ready   = 1'b0;
      rst             = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("reset in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("reset out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("reset result", bus.result, 64'd0);
      check_eq("reset flags", {62'd0, bus.flag_nv, bus.flag_nx}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("release out_valid", 64'(bus.out_valid), 64'd0);

      run_op("1.5 rne",    64'h3FF8000000000000, 1'b0, 3'd0, 64'd2, 1'b0, 1'b1, 9, 5);
      run_op("2.5 rne",    64'h4004000000000000, 1'b0, 3'd0, 64'd2, 1'b0, 1'b1, 9, 0);
      run_op("-2.5 rmm",   64'hC004000000000000, 1'b0, 3'd4, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 9, 0);
      run_op("-2.5 rup",   64'hC004000000000000, 1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 0);
      run_op("-2.5 rtz",   64'hC004000000000000, 1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 0);
      run_op("2^63 s",     64'h43E0000000000000, 1'b0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3, 0);
      run_op("2^63 u",     64'h43E0000000000000, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 3, 0);
      run_op("-2^63 s",    64'hC3E0000000000000, 1'b0, 3'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 3, 0);
      run_op("qnan s",     64'h7FF8000000000000, 1'b0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
      run_op("-inf u",     64'hFFF0000000000000, 1'b1, 3'd0, 64'd0, 1'b1, 1'b0, 1, 0);
      run_op("+0",         64'h0000000000000000, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 2, 0);
      run_op("-0.3 u rtz", 64'hBFD3333333333333, 1'b1, 3'd1, 64'd0, 1'b0, 1'b1, 9, 0);
      run_op("-1.0 u",     64'hBFF0000000000000, 1'b1, 3'd0, 64'd0, 1'b1, 1'b0, 9, 0);
      run_op("2^52 rne",   64'h4330000000000000, 1'b0, 3'd0, 64'h0010_0000_0000_0000, 1'b0, 1'b0, 2, 0);

      // Reset in the middle of a SHIFT sequence.
      wait_ready("rst op");
      bus.operand     = 64'h3FF8000000000000;
      bus.is_unsigned = 1'b0;
      bus.rm          = 3'd0;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid rst out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mid rst in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("after rst out_valid", 64'(bus.out_valid), 64'd0);
      run_op("post rst 1.5", 64'h3FF8000000000000, 1'b0, 3'd0, 64'd2, 1'b0, 1'b1, 9, 0);

      // Randomized operands against the reference.
      for (int k = 0; k < 300; k++) begin
         op  = {$urandom, $urandom};
         cat = int'($urandom_range(0, 9));
         case (cat)
            0: ;
            1: begin
               op[62:52] = 11'h7FF;
               if ($urandom_range(0, 1) == 0) op[51:0] = 52'd0;
            end
            2: op[62:52] = 11'd0;
            default: op[62:52] = 11'(1018 + $urandom_range(0, 72));
         endcase
         if ($urandom_range(0, 2) == 0) op[40:0] = 41'd0;
         uns = 1'($urandom_range(0, 1));
         rmv = 3'($urandom_range(0, 7));
         model(op, uns, rmv, er, env, enx, elat);
         run_op("rand", op, uns, rmv, er, env, enx, elat, int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
